proc_issue_sequencer: RTL and testbench
=======================================

// Module: proc_issue_sequencer
// PURPOSE
//   Sequences 8-bit instruction words into the Processor datapath (drives its sig[7:0] input).
//   Host pushes words into a small FIFO (valid/ready); after start, one word is issued per slot.
//   Multi-cycle ops (opcode sig[7:6]==2'b11) hold off the next issue; HALT word stops sequencing.
// PARAMETERS
//   DEPTH      4     FIFO entries (power of 2, >=2)
//   MC_CYCLES  3     issue-slot length for opcode 2'b11, in cycles (>=1)
//   HALT_CODE  8'hFF instruction word that halts the sequencer (consumed, never issued)
// PORTS
//   clk         in   1   clock, rising edge
//   rst         in   1   reset, asynchronous, active-high
//   in_data     in   8   instruction word from host
//   in_valid    in   1   in_data valid
//   in_ready    out  1   FIFO can accept; transfer when in_valid & in_ready at clk edge
//   start       in   1   one-cycle pulse: IDLE/HALT -> ISSUE
//   sig         out  8   instruction to Processor datapath (registered)
//   sig_valid   out  1   one-cycle pulse per issued instruction (registered)
//   busy        out  1   state is ISSUE or WAIT
//   halted      out  1   state is HALT
//   fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
//   issued_cnt  out  8   count of sig_valid pulses, wraps 255->0
// BEHAVIOUR
//   Reset (async, immediate): state IDLE, FIFO emptied, sig=0, sig_valid=0, busy=0, halted=0,
//     fifo_count=0, issued_cnt=0, wait counter=0. Reset mid-WAIT/ISSUE aborts with no pulse.
//   FIFO: in_ready = (fifo_count < DEPTH), from registered count only; push when full is refused
//     even if a pop occurs that cycle. Push+pop same edge: count unchanged. Word pushed at edge N
//     is poppable at edge N+1 earliest (no fall-through). Pushes accepted in every state.
//   States: IDLE, ISSUE, WAIT, HALT.
//   IDLE: sig_valid=0; start -> ISSUE. FIFO contents are retained, not issued.
//   ISSUE, fifo_count==0: stay, sig_valid=0, sig holds last value (starved).
//   ISSUE, head==HALT_CODE: pop, sig_valid=0, no count -> HALT.
//   ISSUE, other head: pop; sig<=head, sig_valid<=1, issued_cnt+=1.
//     opcode!=2'b11 or MC_CYCLES==1: stay ISSUE (back-to-back issue, 1 word/cycle).
//     opcode==2'b11: -> WAIT, wait counter<=MC_CYCLES-1.
//   WAIT: sig held, sig_valid=0; counter decrements each edge; at counter==1 -> ISSUE.
//     Net: sig_valid pulses after a 2'b11 op are exactly MC_CYCLES cycles apart.
//   HALT: halted=1; start -> ISSUE (halted clears on that edge). start ignored in ISSUE/WAIT.
//   issued_cnt: 8-bit, modulo 256. fifo_count never exceeds DEPTH nor underflows.
// CONFIGURATION
//   SEQ_STEP_EN defined: adds input port `step` (1 bit). In ISSUE, a pop (including HALT_CODE)
//     happens only on edges where step==1; otherwise state holds, sig_valid=0. WAIT unaffected.
//   SEQ_STEP_EN undefined: no step port; ISSUE pops whenever FIFO non-empty (free-running).
// TESTING
//   1 Reset: assert rst mid-run with 3 words queued -> all outputs 0, fifo_count=0, state IDLE.
//   2 Push 0x93,0xA1,0x10 then start -> sig_valid on 3 consecutive cycles, sig=0x93,0xA1,0x10,
//     issued_cnt=3, then starved: busy=1, sig_valid=0, sig stays 0x10.
//   3 Push 0xC8,0x93, start (MC_CYCLES=3) -> 0xC8 pulse, then 0x93 pulse exactly 3 cycles later.
//   4 Fill 4 words without start -> in_ready=0, 5th push refused, fifo_count=4, no sig_valid.
//   5 Push 0x93,0xFF,0xA1, start -> 0x93 issued, halted=1, 0xA1 held (fifo_count=1);
//     second start -> 0xA1 issued, issued_cnt=2.
//   6 SEQ_STEP_EN: 2 words queued, started, step low 5 cycles -> no pulse; step pulse -> one issue.

Source files
------------

// File: rtl/proc_issue_sequencer.sv
// proc_issue_sequencer: host-fed FIFO plus issue FSM driving the Processor sig[7:0] input.
// Ports: clk, rst (async high), in_data/in_valid/in_ready (host push), start (IDLE/HALT -> ISSUE),
//   sig/sig_valid (registered issue), busy, halted, fifo_count, issued_cnt.
//   Optional: define SEQ_STEP_EN to add input `step`, gating every pop in ISSUE.
module proc_issue_sequencer #(
    parameter int         DEPTH     = 4,
    parameter int         MC_CYCLES = 3,
    parameter logic [7:0] HALT_CODE = 8'hFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       start,
`ifdef SEQ_STEP_EN
    input  logic                       step,
`endif
    output logic [7:0]                 sig,
    output logic                       sig_valid,
    output logic                       busy,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MC_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic [WW-1:0]   wcnt;
    logic [7:0]      head;
    logic            push, pop, issue, load_wait, empty, go;

    // in_ready comes from the registered count only, so a pop on
    // the same edge never frees a slot for a concurrent push.
    assign in_ready   = count < CW'(DEPTH);
    assign push       = in_valid & in_ready;
    assign empty      = (count == '0);
    assign head       = mem[rptr];
    assign fifo_count = count;
    assign busy       = (state == S_ISSUE) || (state == S_WAIT);
    assign halted     = (state == S_HALT);

`ifdef SEQ_STEP_EN
    assign go = step;
`else
    assign go = 1'b1;
`endif

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        issue     = 1'b0;
        load_wait = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (!empty && go) begin
                    pop = 1'b1;
                    if (head == HALT_CODE) begin
                        state_n = S_HALT;
                    end else begin
                        issue = 1'b1;
                        if (head[7:6] == 2'b11 && MC_CYCLES > 1) begin
                            state_n   = S_WAIT;
                            load_wait = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (wcnt == WW'(1)) state_n = S_ISSUE;
            end
            S_HALT: begin
                if (start) state_n = S_ISSUE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Loaded with MC_CYCLES-1 on a multi-cycle issue; WAIT exits at 1,
    // so the next pop lands exactly MC_CYCLES edges after this one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (load_wait) begin
            wcnt <= WW'(MC_CYCLES - 1);
        end else if (state == S_WAIT) begin
            wcnt <= wcnt - WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig        <= '0;
            sig_valid  <= 1'b0;
            issued_cnt <= '0;
        end else begin
            sig_valid <= issue;
            if (issue) begin
                sig        <= head;
                issued_cnt <= issued_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_proc_issue_sequencer.sv
// tb_proc_issue_sequencer: directed and randomized bench for proc_issue_sequencer.
// Reference model: word queue, running/halted flags and an earliest-next-issue cycle stamp.
module tb_proc_issue_sequencer;

    localparam int         DEPTH = 4;
    localparam int         MC    = 3;
    localparam logic [7:0] HALTW = 8'hFF;
    localparam int         CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          start = 1'b0;
    logic          step_i = 1'b1;
    logic [7:0]    sig;
    logic          sig_valid;
    logic          busy;
    logic          halted;
    logic [CW-1:0] fifo_count;
    logic [7:0]    issued_cnt;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] q[$];
    bit         m_run;
    bit         m_halt;
    int         cyc;
    int         hold;
    logic [7:0] m_sig;
    logic       m_valid;
    logic [7:0] m_cnt;

    always #5 clk = ~clk;

    proc_issue_sequencer #(
        .DEPTH(DEPTH),
        .MC_CYCLES(MC),
        .HALT_CODE(HALTW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .start(start),
`ifdef SEQ_STEP_EN
        .step(step_i),
`endif
        .sig(sig),
        .sig_valid(sig_valid),
        .busy(busy),
        .halted(halted),
        .fifo_count(fifo_count),
        .issued_cnt(issued_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sig"}, 32'(sig), 32'(m_sig));
        chk({tag, ".sig_valid"}, 32'(sig_valid), 32'(m_valid));
        chk({tag, ".busy"}, 32'(busy), 32'(m_run));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, ".issued_cnt"}, 32'(issued_cnt), 32'(m_cnt));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    endtask

    function automatic void model_reset();
        q.delete();
        m_run   = 1'b0;
        m_halt  = 1'b0;
        hold    = 0;
        m_sig   = '0;
        m_valid = 1'b0;
        m_cnt   = '0;
    endfunction

    // One clock edge of the sequencer as the rules describe it.
    function automatic void model_edge();
        logic [7:0] w;
        bit         room;
        bit         step_ok;
`ifdef SEQ_STEP_EN
        step_ok = step_i;
`else
        step_ok = 1'b1;
`endif
        room    = q.size() < DEPTH;
        m_valid = 1'b0;
        if (m_run && cyc >= hold && q.size() > 0 && step_ok) begin
            w = q.pop_front();
            if (w == HALTW) begin
                m_run  = 1'b0;
                m_halt = 1'b1;
            end else begin
                m_sig   = w;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 8'd1;
                hold    = (w[7:6] == 2'b11) ? cyc + MC : cyc + 1;
            end
        end else if (!m_run && start) begin
            m_run  = 1'b1;
            m_halt = 1'b0;
            hold   = cyc + 1;
        end
        if (in_valid && room) q.push_back(in_data);
        cyc++;
    endfunction

    task automatic tick(input logic v, input logic [7:0] d, input logic st);
        in_valid = v;
        in_data  = d;
        start    = st;
        model_edge();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        check_all("cyc");
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("por");
        rst = 1'b0;

        // 1: reset mid-WAIT with 3 words queued
        tick(1, 8'hC8, 0);
        tick(1, 8'h10, 0);
        tick(1, 8'h20, 0);
        tick(1, 8'h30, 1);
        tick(0, 8'h00, 0);
        chk("t1_issue", 32'(sig), 32'hC8);
        tick(0, 8'h00, 0);
        chk("t1_queued", 32'(fifo_count), 32'd3);
        do_reset("t1_rst");
        chk("t1_count0", 32'(fifo_count), 32'd0);
        chk("t1_busy0", 32'(busy), 32'd0);
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 0);

        // 2: back-to-back issue then starvation
        do_reset("t2_rst");
        tick(1, 8'h93, 0);
        tick(1, 8'hA1, 0);
        tick(1, 8'h10, 0);
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
        chk("t2_w0", 32'({sig_valid, sig}), 32'h193);
        tick(0, 8'h00, 0);
        chk("t2_w1", 32'({sig_valid, sig}), 32'h1A1);
        tick(0, 8'h00, 0);
        chk("t2_w2", 32'({sig_valid, sig}), 32'h110);
        chk("t2_cnt", 32'(issued_cnt), 32'd3);
        tick(0, 8'h00, 0);
        chk("t2_starve", 32'({busy, sig_valid, sig}), 32'h210);

        // 3: multi-cycle spacing
        do_reset("t3_rst");
        tick(1, 8'hC8, 0);
        tick(1, 8'h93, 0);
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
        chk("t3_mc", 32'({sig_valid, sig}), 32'h1C8);
        tick(0, 8'h00, 0);
        chk("t3_gap1", 32'(sig_valid), 32'd0);
        tick(0, 8'h00, 0);
        chk("t3_gap2", 32'(sig_valid), 32'd0);
        tick(0, 8'h00, 0);
        chk("t3_next", 32'({sig_valid, sig}), 32'h193);

        // 4: full FIFO refuses a push
        do_reset("t4_rst");
        for (int i = 0; i < DEPTH; i++) tick(1, 8'(8'h40 + i), 0);
        chk("t4_ready", 32'(in_ready), 32'd0);
        tick(1, 8'h55, 0);
        chk("t4_count", 32'(fifo_count), 32'd4);
        chk("t4_novalid", 32'(sig_valid), 32'd0);

        // 5: HALT word, then restart
        do_reset("t5_rst");
        tick(1, 8'h93, 0);
        tick(1, HALTW, 0);
        tick(1, 8'hA1, 0);
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
        chk("t5_w0", 32'({sig_valid, sig}), 32'h193);
        tick(0, 8'h00, 0);
        chk("t5_halt", 32'({halted, fifo_count}), 32'({1'b1, CW'(1)}));
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 1);
        chk("t5_unhalt", 32'(halted), 32'd0);
        tick(0, 8'h00, 0);
        chk("t5_w1", 32'({sig_valid, sig}), 32'h1A1);
        chk("t5_cnt", 32'(issued_cnt), 32'd2);

`ifdef SEQ_STEP_EN
        // 6: step gating
        do_reset("t6_rst");
        step_i = 1'b0;
        tick(1, 8'h12, 0);
        tick(1, 8'h34, 0);
        tick(0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 8'h00, 0);
            chk("t6_hold", 32'(sig_valid), 32'd0);
        end
        step_i = 1'b1;
        tick(0, 8'h00, 0);
        step_i = 1'b0;
        chk("t6_step", 32'({sig_valid, sig}), 32'h112);
        tick(0, 8'h00, 0);
        chk("t6_one", 32'({sig_valid, fifo_count}), 32'(CW'(1)));
        step_i = 1'b1;
`endif

        // randomized traffic against the model
        do_reset("rnd_rst");
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 11) == 0) ? HALTW : 8'($urandom);
`ifdef SEQ_STEP_EN
            step_i = ($urandom_range(0, 3) != 0);
`endif
            tick(($urandom_range(0, 2) != 0), d, ($urandom_range(0, 7) == 0));
            if (i == 300) do_reset("rnd_mid_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
